conv_inst_sequencer: RTL
========================

// Module: conv_inst_sequencer
// PURPOSE
//  On-chip instruction generator for core: drives the 35-bit inst word that a host otherwise sequences by hand.
//  Runs a full conv tile: per kij, weights xmem->L0->PEs, activations xmem->L0, execute, drain, OFIFO->pmem.
//  It then runs the accumulation/relu read-out over pmem. It sits between the host start/done handshake and core.inst.
// PARAMETERS
//  col 8 | array columns; weight words per kij = col (mode=0) or 2*col (mode=1, SIMD 2-bit)
//  len_kij 9 | kernel taps; len_nij 36 | padded input pixels; len_onij 16 | output pixels
//  a_pad_ni_dim 6 | padded input width; o_ni_dim 4 | output width; ki_dim 3 | kernel width
//  W_ADDR_START 11'h400 | weight base in xmem; W_ADDR_OFFSET 11'h010 | xmem stride per kij
//  SETTLE 10 | idle cycles after PE load
// PORTS
//  clk          in   1    clock
//  reset        in   1    synchronous, active-high
//  start        in   1    1-cycle pulse; accepted only in IDLE
//  mode         in   1    0 normal, 1 SIMD; sampled at accepted start, held for the run
//  ofifo_valid  in   1    core OFIFO has a full row
//  inst         out  35   core instruction, registered; field map below
//  busy         out  1    high from the cycle after an accepted start until done
//  done         out  1    1-cycle pulse when the last relu is issued
//  kij_idx      out  4    current kernel tap (0..len_kij-1); 0 during ACC and IDLE
// BEHAVIOUR
//  inst map: [34]relu [33]acc [32]CEN_pmem [31]WEN_pmem [30:20]A_pmem [19]CEN_xmem [18]WEN_xmem [17:7]A_xmem
//            [6]ofifo_rd [5]ififo_wr [4]ififo_rd [3]l0_rd [2]l0_wr [1]execute [0]load. All outputs are flops.
//  Idle word NOP = 35'h1_800C_0000 (CEN/WEN high, all else 0). Reset: inst=NOP, busy=0, done=0, kij_idx=0, state IDLE.
//  ififo_wr and ififo_rd are always 0; WEN_xmem is always 1 (xmem is pre-loaded by the host).
//  xmem/pmem reads have 1-cycle latency. Every L0 write is issued exactly one cycle after its CEN_xmem read.
//  States and cycle counts (NW = col<<mode):
//   IDLE:   emit NOP; on start -> W_L0.
//   W_L0:   NW reads with A_xmem = W_ADDR_START + kij*W_ADDR_OFFSET + n; l0_wr trails CEN_xmem by 1 cycle.
//           Then one NOP cycle -> W_LOAD.
//   W_LOAD: NW cycles of l0_rd=1, load=1 -> SETTLE.
//   SETTLE: SETTLE cycles of NOP -> A_L0.
//   A_L0:   len_nij reads, A_xmem = 0..len_nij-1, l0_wr trailing by 1 -> EXEC.
//   EXEC:   len_nij cycles of l0_rd=1, execute=1 -> DRAIN.
//   DRAIN:  len_nij NOP cycles -> OF_RD.
//   OF_RD:  len_nij pops. Assert ofifo_rd only while ofifo_valid=1; if ofifo_valid=0, stall (ofifo_rd=0, state held).
//           Each pop is followed 1 cycle later by a pmem write: CEN=0, WEN=0, A_pmem = kij*len_nij + n.
//           After the last write: kij<len_kij-1 -> kij++, W_L0; else -> ACC.
//   ACC:    for o = 0..len_onij-1:
//           len_kij read cycles: CEN_pmem=0, WEN_pmem=1,
//             A_pmem = (o/o_ni_dim)*a_pad_ni_dim + o%o_ni_dim + (j/ki_dim)*a_pad_ni_dim + j%ki_dim + j*len_nij.
//           acc=1 on cycles j=1..len_kij, one cycle past the last read.
//           Then 1 cycle relu=1, then 1 NOP cycle.
//           Generate addresses with row/col counters; no dividers.
//           After o=len_onij-1: done=1 for 1 cycle, busy=0 -> IDLE.
//  start while busy: ignored. reset mid-run: next cycle inst=NOP and state IDLE; partial pmem content is not cleaned.
//  Addresses are 11-bit, wrapping mod 2048. With default parameters, pmem stays below 9*36=324.
// TESTING
//  T1 reset: hold reset 3 cycles mid-EXEC -> inst==35'h1_800C_0000, busy=0 the next cycle.
//  T2 mode=0, kij0: W_L0 issues A_xmem 0x400..0x407, l0_wr high 8 cycles each lagging CEN by 1; W_LOAD 8 cycles.
//  T3 mode=1, kij3: first weight address 0x430, 16 reads, W_LOAD 16 cycles.
//  T4 ofifo_valid low for 5 cycles during OF_RD kij2 -> no ofifo_rd/pmem write in those cycles;
//     writes still cover A_pmem 72..107 exactly once.
//  T5 ACC o=5: A_pmem seq 7,44,81,121,158,195,235,272,309; acc high 9 cycles; relu 1 cycle.
//  T6 full run with core + golden 2-bit data: all 16 sfp_out rows match out.txt; done pulses once; start during busy has no effect.

Source files
------------

// File: rtl/conv_inst_sequencer.sv
// conv_inst_sequencer
//  On-chip instruction generator for the conv core. One accepted start runs a
//  full tile for every kernel tap (weights xmem->L0->PEs, activations
//  xmem->L0, execute, drain, OFIFO->pmem). It then runs the accumulate/relu
//  read-out over pmem for every output pixel.
// Ports
//  clk, reset    clock, synchronous active-high reset
//  start, mode   start pulse (IDLE only); mode 0 normal / 1 SIMD, latched at start
//  ofifo_valid   core OFIFO holds a full row
//  inst[34:0]    registered core instruction word
//  busy, done    run in progress / 1-cycle pulse with the final relu
//  kij_idx[3:0]  current kernel tap, 0 outside the tile phases
module conv_inst_sequencer #(
  parameter int          col           = 8,
  parameter int          len_kij       = 9,
  parameter int          len_nij       = 36,
  parameter int          len_onij      = 16,
  parameter int          a_pad_ni_dim  = 6,
  parameter int          o_ni_dim      = 4,
  parameter int          ki_dim        = 3,
  parameter logic [10:0] W_ADDR_START  = 11'h400,
  parameter logic [10:0] W_ADDR_OFFSET = 11'h010,
  parameter int          SETTLE        = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        mode,
  input  logic        ofifo_valid,
  output logic [34:0] inst,
  output logic        busy,
  output logic        done,
  output logic [3:0]  kij_idx
);

  typedef struct packed {
    logic        relu;
    logic        acc;
    logic        cen_pmem;
    logic        wen_pmem;
    logic [10:0] a_pmem;
    logic        cen_xmem;
    logic        wen_xmem;
    logic [10:0] a_xmem;
    logic        ofifo_rd;
    logic        ififo_wr;
    logic        ififo_rd;
    logic        l0_rd;
    logic        l0_wr;
    logic        execute;
    logic        load;
  } inst_t;

  typedef enum logic [3:0] {
    IDLE, W_L0, W_LOAD, SETTLE_S, A_L0, EXEC, DRAIN, OF_RD, ACC
  } state_t;

  localparam int    CW  = $clog2(len_nij + 2*col + SETTLE + len_kij + len_onij + 4);
  localparam inst_t NOP = inst_t'(35'h1_800C_0000);

  // Address steps for the divider-free read-out walk.
  localparam logic [10:0] TAP_STEP = 11'(1 + len_nij);
  localparam logic [10:0] TAP_WRAP = 11'(a_pad_ni_dim - ki_dim + 1 + len_nij);
  localparam logic [10:0] OB_WRAP  = 11'(a_pad_ni_dim - o_ni_dim + 1);

  state_t         state;
  inst_t          inst_q, nx;
  logic           mode_q;
  logic [3:0]     kij;
  logic [CW-1:0]  cnt, pops, wcnt, ocnt, ocol, kcol, nw;
  logic [10:0]    wbase, pbase, obase, tap;

  assign nw      = mode_q ? CW'(2*col) : CW'(col);
  assign inst    = inst_q;
  assign kij_idx = kij;

  // Next instruction word. L0 writes simply echo last cycle's xmem read, which
  // gives the 1-cycle read latency alignment everywhere for free.
  always_comb begin
    nx       = NOP;
    nx.l0_wr = ~inst_q.cen_xmem;
    case (state)
      W_L0: if (cnt < nw) begin
        nx.cen_xmem = 1'b0;
        nx.a_xmem   = wbase + 11'(cnt);
      end
      W_LOAD: begin
        nx.l0_rd = 1'b1;
        nx.load  = 1'b1;
      end
      A_L0: if (cnt < CW'(len_nij)) begin
        nx.cen_xmem = 1'b0;
        nx.a_xmem   = 11'(cnt);
      end
      EXEC: begin
        nx.l0_rd   = 1'b1;
        nx.execute = 1'b1;
      end
      OF_RD: begin
        nx.ofifo_rd = ofifo_valid && (pops < CW'(len_nij));
        // pmem write lands one cycle after its pop
        if (inst_q.ofifo_rd) begin
          nx.cen_pmem = 1'b0;
          nx.wen_pmem = 1'b0;
          nx.a_pmem   = pbase + 11'(wcnt);
        end
      end
      ACC: begin
        if (cnt < CW'(len_kij)) begin
          nx.cen_pmem = 1'b0;
          nx.a_pmem   = obase + tap;
        end
        nx.acc  = (cnt >= CW'(1)) && (cnt <= CW'(len_kij));
        nx.relu = (cnt == CW'(len_kij + 1));
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      inst_q <= NOP;
      busy   <= 1'b0;
      done   <= 1'b0;
      mode_q <= 1'b0;
      kij    <= '0;
      cnt    <= '0;
      pops   <= '0;
      wcnt   <= '0;
      ocnt   <= '0;
      ocol   <= '0;
      kcol   <= '0;
      wbase  <= W_ADDR_START;
      pbase  <= '0;
      obase  <= '0;
      tap    <= '0;
    end else begin
      inst_q <= nx;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          // busy is still high in the done cycle, so a start there is dropped
          if (start && !busy) begin
            state  <= W_L0;
            busy   <= 1'b1;
            mode_q <= mode;
            kij    <= '0;
            cnt    <= '0;
            wbase  <= W_ADDR_START;
            pbase  <= '0;
          end
        end
        W_L0: begin
          cnt <= cnt + CW'(1);
          if (cnt == nw) begin cnt <= '0; state <= W_LOAD; end
        end
        W_LOAD: begin
          cnt <= cnt + CW'(1);
          if (cnt == nw - CW'(1)) begin cnt <= '0; state <= SETTLE_S; end
        end
        SETTLE_S: begin
          cnt <= cnt + CW'(1);
          if (cnt == CW'(SETTLE - 1)) begin cnt <= '0; state <= A_L0; end
        end
        A_L0: begin
          cnt <= cnt + CW'(1);
          if (cnt == CW'(len_nij)) begin cnt <= '0; state <= EXEC; end
        end
        EXEC: begin
          cnt <= cnt + CW'(1);
          if (cnt == CW'(len_nij - 1)) begin cnt <= '0; state <= DRAIN; end
        end
        DRAIN: begin
          cnt <= cnt + CW'(1);
          if (cnt == CW'(len_nij - 1)) begin
            cnt   <= '0;
            pops  <= '0;
            wcnt  <= '0;
            state <= OF_RD;
          end
        end
        OF_RD: begin
          if (nx.ofifo_rd) pops <= pops + CW'(1);
          if (inst_q.ofifo_rd) begin
            wcnt <= wcnt + CW'(1);
            if (wcnt == CW'(len_nij - 1)) begin
              cnt <= '0;
              if (kij == 4'(len_kij - 1)) begin
                state <= ACC;
                kij   <= '0;
                ocnt  <= '0;
                ocol  <= '0;
                kcol  <= '0;
                obase <= '0;
                tap   <= '0;
              end else begin
                state <= W_L0;
                kij   <= kij + 4'd1;
                wbase <= wbase + W_ADDR_OFFSET;
                pbase <= pbase + 11'(len_nij);
              end
            end
          end
        end
        ACC: begin
          cnt <= cnt + CW'(1);
          // tap = (j/ki_dim)*a_pad + j%ki_dim + j*len_nij, stepped per read
          if (cnt < CW'(len_kij)) begin
            if (kcol == CW'(ki_dim - 1)) begin
              kcol <= '0;
              tap  <= tap + TAP_WRAP;
            end else begin
              kcol <= kcol + CW'(1);
              tap  <= tap + TAP_STEP;
            end
          end
          if (cnt == CW'(len_kij + 1) && ocnt == CW'(len_onij - 1)) begin
            done  <= 1'b1;
            state <= IDLE;
          end
          // end of one output pixel (after the trailing NOP)
          if (cnt == CW'(len_kij + 2)) begin
            cnt  <= '0;
            ocnt <= ocnt + CW'(1);
            kcol <= '0;
            tap  <= '0;
            if (ocol == CW'(o_ni_dim - 1)) begin
              ocol  <= '0;
              obase <= obase + OB_WRAP;
            end else begin
              ocol  <= ocol + CW'(1);
              obase <= obase + 11'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
